// File: rtl/shaft_pkg.sv
// Shared encodings for the shaft emulator: engine/door command codes,
// sensor_door codes and the door actuator state set.
package shaft_pkg;

    localparam logic [1:0] ENG_STOP    = 2'b00;
    localparam logic [1:0] ENG_UP      = 2'b01;
    localparam logic [1:0] ENG_DOWN    = 2'b10;
    localparam logic [1:0] ENG_ILLEGAL = 2'b11;

    localparam logic [1:0] DOOR_HOLD    = 2'b00;
    localparam logic [1:0] DOOR_OPEN    = 2'b01;
    localparam logic [1:0] DOOR_CLOSE   = 2'b10;
    localparam logic [1:0] DOOR_ILLEGAL = 2'b11;

    localparam logic [1:0] SD_MOVING = 2'b00;
    localparam logic [1:0] SD_OPEN   = 2'b01;
    localparam logic [1:0] SD_CLOSED = 2'b10;

    typedef enum logic [1:0] {
        DS_CLOSED,
        DS_OPENING,
        DS_OPEN,
        DS_CLOSING
    } door_state_t;

endpackage

// File: rtl/shaft_door_actuator.sv
// Door FSM with stroke counter; SHAFT_DOOR_OBSTRUCT_EN adds the obstruct
// input that bounces a closing door back to opening.
module shaft_door_actuator
    import shaft_pkg::*;
#(
    parameter int DOOR_TICKS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] door_cmd,
`ifdef SHAFT_DOOR_OBSTRUCT_EN
    input  logic       obstruct,
`endif
    input  logic       freeze,
    output logic       door_closed,
    output logic [1:0] sensor_door
);

    localparam int CW = $clog2(DOOR_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DOOR_TICKS - 1);

    door_state_t   state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    sd_nx;
    logic          reopen;

`ifdef SHAFT_DOOR_OBSTRUCT_EN
    assign reopen = obstruct;
`else
    assign reopen = 1'b0;
`endif

    assign door_closed = (state == DS_CLOSED);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= DS_CLOSED;
            cnt         <= '0;
            sensor_door <= SD_CLOSED;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            sensor_door <= sd_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sd_nx    = sensor_door;
        if (!freeze) begin
            case (state)
                DS_CLOSED: begin
                    if (door_cmd == DOOR_OPEN) begin
                        state_nx = DS_OPENING;
                        cnt_nx   = '0;
                        sd_nx    = SD_MOVING;
                    end
                end
                DS_OPENING: begin
                    if (door_cmd == DOOR_CLOSE) begin
                        state_nx = DS_CLOSING;
                        cnt_nx   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nx = DS_OPEN;
                        sd_nx    = SD_OPEN;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                DS_OPEN: begin
                    if (door_cmd == DOOR_CLOSE) begin
                        state_nx = DS_CLOSING;
                        cnt_nx   = '0;
                        sd_nx    = SD_MOVING;
                    end
                end
                DS_CLOSING: begin
                    if (door_cmd == DOOR_OPEN || reopen) begin
                        state_nx = DS_OPENING;
                        cnt_nx   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nx = DS_CLOSED;
                        sd_nx    = SD_CLOSED;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                default: begin
                    state_nx = DS_CLOSED;
                    cnt_nx   = '0;
                    sd_nx    = SD_CLOSED;
                end
            endcase
        end
    end

endmodule

// File: rtl/shaft_emulator.sv
// Cab/shaft/door plant: position counter, floor arrival pulses and sticky
// fault detection. SHAFT_DOOR_OBSTRUCT_EN adds the obstruct input.
module shaft_emulator
    import shaft_pkg::*;
#(
    parameter int FLOORS      = 8,
    parameter int FLOOR_TICKS = 16,
    parameter int DOOR_TICKS  = 8,
    parameter int START_FLOOR = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                engine,
    input  logic [1:0]                door,
`ifdef SHAFT_DOOR_OBSTRUCT_EN
    input  logic                      obstruct,
`endif
    output logic                      sensor_up,
    output logic                      sensor_down,
    output logic [1:0]                sensor_door,
    output logic [$clog2(FLOORS)-1:0] cab_floor,
    output logic                      fault
);

    localparam int FW = $clog2(FLOORS);
    localparam int PW = $clog2(FLOOR_TICKS);
    localparam logic [FW-1:0] TOP_SEG = FW'(FLOORS - 1);
    localparam logic [PW-1:0] PH_LAST = PW'(FLOOR_TICKS - 1);

    // pos is held as (seg, phase): seg = floor at or below the cab, phase = ticks above it
    logic [FW-1:0] seg, seg_nx, floor_nx;
    logic [PW-1:0] phase, phase_nx;
    logic          up_nx, dn_nx;
    logic          violation, freeze, door_closed;
    logic          at_top, at_bottom;

    shaft_door_actuator #(
        .DOOR_TICKS (DOOR_TICKS)
    ) u_door (
        .clk         (clk),
        .reset       (reset),
        .door_cmd    (door),
`ifdef SHAFT_DOOR_OBSTRUCT_EN
        .obstruct    (obstruct),
`endif
        .freeze      (freeze),
        .door_closed (door_closed),
        .sensor_door (sensor_door)
    );

    assign at_bottom = (seg == '0) && (phase == '0);
    assign at_top    = (seg == TOP_SEG) && (phase == '0);

    always_comb begin
        violation = (engine == ENG_ILLEGAL) || (door == DOOR_ILLEGAL)
                 || (engine != ENG_STOP && !door_closed)
                 || (door == DOOR_OPEN && engine != ENG_STOP)
                 || (engine == ENG_UP && at_top)
                 || (engine == ENG_DOWN && at_bottom);
        freeze = fault || violation;

        seg_nx   = seg;
        phase_nx = phase;
        floor_nx = cab_floor;
        up_nx    = 1'b0;
        dn_nx    = 1'b0;
        if (!freeze) begin
            if (engine == ENG_UP) begin
                if (phase == PH_LAST) begin
                    phase_nx = '0;
                    seg_nx   = seg + FW'(1);
                    floor_nx = seg + FW'(1);
                    up_nx    = 1'b1;
                end else begin
                    phase_nx = phase + PW'(1);
                end
            end else if (engine == ENG_DOWN) begin
                // leaving a floor downward drops seg; arriving lands back on seg
                if (phase == '0) begin
                    phase_nx = PH_LAST;
                    seg_nx   = seg - FW'(1);
                end else begin
                    phase_nx = phase - PW'(1);
                    if (phase == PW'(1)) begin
                        floor_nx = seg;
                        dn_nx    = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg         <= FW'(START_FLOOR);
            phase       <= '0;
            cab_floor   <= FW'(START_FLOOR);
            sensor_up   <= 1'b0;
            sensor_down <= 1'b0;
            fault       <= 1'b0;
        end else begin
            seg         <= seg_nx;
            phase       <= phase_nx;
            cab_floor   <= floor_nx;
            sensor_up   <= up_nx;
            sensor_down <= dn_nx;
            fault       <= fault || violation;
        end
    end

endmodule

// File: tb/tb_shaft_emulator.sv
// Self-checking bench for shaft_emulator against an integer-position plant
// model; covers SHAFT_DOOR_OBSTRUCT_EN when that macro is defined.
module tb_shaft_emulator;

    localparam int FLOORS = 8;
    localparam int FT     = 4;
    localparam int DT     = 8;
    localparam int TOP    = (FLOORS - 1) * FT;
`ifdef SHAFT_DOOR_OBSTRUCT_EN
    localparam bit OBS_EN = 1'b1;
`else
    localparam bit OBS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] engine = 2'b00;
    logic [1:0] door = 2'b00;
    logic       obstruct_i = 1'b0;
    logic       sensor_up, sensor_down, fault;
    logic [1:0] sensor_door;
    logic [2:0] cab_floor;

    always #5 clk = ~clk;

    shaft_emulator #(
        .FLOORS      (FLOORS),
        .FLOOR_TICKS (FT),
        .DOOR_TICKS  (DT),
        .START_FLOOR (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .engine      (engine),
        .door        (door),
`ifdef SHAFT_DOOR_OBSTRUCT_EN
        .obstruct    (obstruct_i),
`endif
        .sensor_up   (sensor_up),
        .sensor_down (sensor_down),
        .sensor_door (sensor_door),
        .cab_floor   (cab_floor),
        .fault       (fault)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // plant model: absolute position, door target plus ticks of travel left
    int m_pos, m_floor, m_rem;
    bit m_up, m_dn, m_fault, m_open_tgt;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_sd();
        if (m_rem > 0) return 0;
        return m_open_tgt ? 1 : 2;
    endfunction

    function automatic bit door_busy();
        return m_open_tgt || (m_rem > 0);
    endfunction

    task automatic model_reset();
        m_pos = 0; m_floor = 0; m_rem = 0;
        m_up = 0; m_dn = 0; m_fault = 0; m_open_tgt = 0;
    endtask

    task automatic model_step(input int e, input int d, input bit o);
        int  npos;
        bit  viol;
        m_up = 0;
        m_dn = 0;
        if (m_fault) return;
        viol = (e == 3) || (d == 3) || (e != 0 && door_busy()) || (d == 1 && e != 0)
            || (e == 1 && m_pos == TOP) || (e == 2 && m_pos == 0);
        if (viol) begin
            m_fault = 1;
            return;
        end
        npos = m_pos + (e == 1 ? 1 : 0) - (e == 2 ? 1 : 0);
        if (npos != m_pos && npos % FT == 0) begin
            m_floor = npos / FT;
            m_up = (npos > m_pos);
            m_dn = (npos < m_pos);
        end
        m_pos = npos;
        if (d == 1 && !m_open_tgt) begin
            m_open_tgt = 1; m_rem = DT;
        end else if (d == 2 && m_open_tgt) begin
            m_open_tgt = 0; m_rem = DT;
        end else if (o && !m_open_tgt && m_rem > 0) begin
            m_open_tgt = 1; m_rem = DT;
        end else if (m_rem > 0) begin
            m_rem--;
        end
    endtask

    task automatic compare_all();
        check("sensor_up",   int'(sensor_up),   int'(m_up));
        check("sensor_down", int'(sensor_down), int'(m_dn));
        check("sensor_door", int'(sensor_door), exp_sd());
        check("cab_floor",   int'(cab_floor),   m_floor);
        check("fault",       int'(fault),       int'(m_fault));
    endtask

    task automatic step(input logic [1:0] e, input logic [1:0] d, input logic o);
        engine     = e;
        door       = d;
        obstruct_i = OBS_EN ? o : 1'b0;
        @(posedge clk);
        #1;
        model_step(int'(engine), int'(door), obstruct_i);
        compare_all();
    endtask

    // asynchronous reset applied between edges; outputs must clear at once
    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_up, n_dn, first_up, last_up, prev_up, gap_bad, n_moving;
        logic [1:0] e_r, d_r;
        int dir, since_fault, since_reset;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        check("reset_sd_literal", int'(sensor_door), 2);
        check("reset_floor_literal", int'(cab_floor), 0);
        @(negedge clk);
        reset = 1'b1;
        step(2'b00, 2'b00, 1'b0);

        // climb the whole shaft
        n_up = 0; first_up = -1; last_up = -1; prev_up = -1; gap_bad = 0;
        for (int i = 0; i < 28; i++) begin
            step(2'b01, 2'b00, 1'b0);
            if (sensor_up) begin
                n_up++;
                if (first_up < 0) first_up = i;
                if (prev_up >= 0 && i - prev_up != 4) gap_bad++;
                prev_up = i;
                last_up = i;
            end
        end
        check("climb_pulses", n_up, 7);
        check("climb_first_pulse", first_up, 3);
        check("climb_last_pulse", last_up, 27);
        check("climb_gap_errors", gap_bad, 0);
        check("climb_floor_literal", int'(cab_floor), 7);
        repeat (3) step(2'b00, 2'b00, 1'b0);

        // reversal mid-span back to floor 7
        n_up = 0; n_dn = 0;
        for (int i = 0; i < 4; i++) begin
            step(i < 2 ? 2'b10 : 2'b01, 2'b00, 1'b0);
            n_up += int'(sensor_up);
            n_dn += int'(sensor_down);
        end
        check("reversal_up_pulses", n_up, 1);
        check("reversal_down_pulses", n_dn, 0);
        check("reversal_floor", int'(cab_floor), 7);
        check("reversal_fault", int'(fault), 0);

        // door open stroke then close stroke
        step(2'b00, 2'b01, 1'b0);
        n_moving = 0;
        for (int k = 0; k < 20 && sensor_door == 2'b00; k++) begin
            n_moving++;
            step(2'b00, 2'b00, 1'b0);
        end
        check("open_stroke_len", n_moving, 8);
        check("open_final", int'(sensor_door), 1);
        step(2'b00, 2'b10, 1'b0);
        n_moving = 0;
        for (int k = 0; k < 20 && sensor_door == 2'b00; k++) begin
            n_moving++;
            step(2'b00, 2'b00, 1'b0);
        end
        check("close_stroke_len", n_moving, 8);
        check("close_final", int'(sensor_door), 2);

        // moving with the door open is a fault and freezes the cab
        step(2'b00, 2'b01, 1'b0);
        repeat (8) step(2'b00, 2'b00, 1'b0);
        step(2'b01, 2'b00, 1'b0);
        check("door_open_move_fault", int'(fault), 1);
        step(2'b01, 2'b00, 1'b0);
        check("frozen_floor", int'(cab_floor), 7);
        check("frozen_sd", int'(sensor_door), 1);
        do_reset();
        check("fault_cleared", int'(fault), 0);
        step(2'b10, 2'b00, 1'b0);
        check("bottom_down_fault", int'(fault), 1);
        do_reset();
        repeat (28) step(2'b01, 2'b00, 1'b0);
        step(2'b01, 2'b00, 1'b0);
        check("top_up_fault", int'(fault), 1);
        check("top_up_no_pulse", int'(sensor_up), 0);
        do_reset();

        // reset mid-span and mid-stroke
        repeat (6) step(2'b01, 2'b00, 1'b0);
        check("midspan_floor", int'(cab_floor), 1);
        do_reset();
        check("midspan_reset_floor", int'(cab_floor), 0);
        step(2'b00, 2'b01, 1'b0);
        repeat (3) step(2'b00, 2'b00, 1'b0);
        do_reset();
        check("midstroke_reset_sd", int'(sensor_door), 2);

`ifdef SHAFT_DOOR_OBSTRUCT_EN
        step(2'b00, 2'b01, 1'b0);
        repeat (8) step(2'b00, 2'b00, 1'b0);
        step(2'b00, 2'b10, 1'b0);
        step(2'b00, 2'b00, 1'b0);
        step(2'b00, 2'b00, 1'b1);
        n_moving = 0;
        for (int k = 0; k < 20 && sensor_door == 2'b00; k++) begin
            n_moving++;
            step(2'b00, 2'b00, 1'b0);
        end
        check("obstruct_reopen_len", n_moving, 8);
        check("obstruct_final", int'(sensor_door), 1);
        step(2'b00, 2'b10, 1'b0);
        repeat (8) step(2'b00, 2'b00, 1'b0);
        step(2'b00, 2'b00, 1'b1);
        check("obstruct_closed_ignored", int'(sensor_door), 2);
`endif

        // randomized closed-loop traffic
        dir = 1; since_fault = 0; since_reset = 0;
        for (int i = 0; i < 3000; i++) begin
            if ((m_fault && since_fault > 3) || since_reset > 600) begin
                do_reset();
                since_fault = 0;
                since_reset = 0;
            end
            if ($urandom_range(0, 99) < 2) begin
                e_r = 2'($urandom_range(0, 3));
                d_r = 2'($urandom_range(0, 3));
            end else if (door_busy()) begin
                e_r = 2'b00;
                case ($urandom_range(0, 9))
                    0, 1:    d_r = 2'b01;
                    2, 3:    d_r = 2'b10;
                    default: d_r = 2'b00;
                endcase
            end else begin
                if ($urandom_range(0, 9) == 0) dir = $urandom_range(0, 2);
                if (dir == 1 && m_pos == TOP) dir = 2;
                if (dir == 2 && m_pos == 0) dir = 1;
                e_r = 2'(dir);
                d_r = 2'b00;
                if (dir == 0 && $urandom_range(0, 3) == 0) d_r = 2'b01;
            end
            step(e_r, d_r, $urandom_range(0, 9) == 0);
            since_reset++;
            if (m_fault) since_fault++;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
